// File: rtl/flux_fifo_if.sv
// Write and read port bundles for flux_fifo; "fifo" modports face the FIFO, "master" modports face producer/consumer.
// Write side: strobe plus {tag, data}, with per-flux full. Read side: per-flux strobe, empty and head data.
interface write_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 28
);
  logic             write;
  logic [WIDTH-1:0] din;
  logic [FLUX-1:0]  full;

  modport fifo   (input  write, input  din, output full);
  modport master (output write, output din, input  full);
endinterface

interface read_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 28
);
  logic [FLUX-1:0]  read;
  logic [FLUX-1:0]  empty;
  logic [WIDTH-1:0] dout;

  modport fifo   (input  read, output empty, output dout);
  modport master (output read, input  empty, input  dout);
endinterface

// File: rtl/flux_fifo.sv
// Multi-flux tagged FIFO: one circular buffer per flux; writes become visible one cycle later, dout is combinational.
// Writes to a full flux / reads of an empty flux are dropped; define FIFO_ERR_FLAG_EN to add a sticky err output.
module flux_fifo #(
  parameter  int FLUX       = 2,
  parameter  int DATA_WIDTH = 27,
  parameter  int DEPTH      = 4,
  localparam int TAG_WIDTH  = $clog2(FLUX),
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  write_interface.fifo   write_port,
  read_interface.fifo    read_port
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic           err
`endif
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam int                   CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TAG_WIDTH:0]   FLUX_LIM = (TAG_WIDTH + 1)'(FLUX);

  logic [PTR_W-1:0]      wptr_q  [FLUX];
  logic [PTR_W-1:0]      wptr_d  [FLUX];
  logic [PTR_W-1:0]      rptr_q  [FLUX];
  logic [PTR_W-1:0]      rptr_d  [FLUX];
  logic [CNT_W-1:0]      count_q [FLUX];
  logic [CNT_W-1:0]      count_d [FLUX];
  logic [DATA_WIDTH-1:0] mem_q   [FLUX][DEPTH];

  logic [FLUX-1:0]       full;
  logic [FLUX-1:0]       empty;
  logic [FLUX-1:0]       wr_hit;
  logic [FLUX-1:0]       rd_first;
  logic [FLUX-1:0]       rd_hit;
  logic [TAG_WIDTH-1:0]  wr_tag;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  tag_ok;
  logic [TAG_WIDTH-1:0]  sel_idx;
  logic                  sel_found;

  assign wr_tag  = write_port.din[WIDTH-1 -: TAG_WIDTH];
  assign wr_data = write_port.din[DATA_WIDTH-1:0];
  assign tag_ok  = {1'b0, wr_tag} < FLUX_LIM;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < FLUX; i++) begin
      full[i]  = (count_q[i] == CNT_FULL);
      empty[i] = (count_q[i] == '0);
    end
  end

  assign write_port.full  = full;
  assign read_port.empty  = empty;

  // Acceptance is judged on pre-edge flags only, so a same-cycle read never frees space for a write.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (write_port.write && tag_ok && (wr_tag == TAG_WIDTH'(i)) && !full[i]) begin
        wr_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_first = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (read_port.read[i]) begin
        rd_first    = '0;
        rd_first[i] = 1'b1;
      end
    end
  end

  assign rd_hit = rd_first & ~empty;

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      count_d[i] = count_q[i];
      if (wr_hit[i]) wptr_d[i] = wptr_q[i] + PTR_W'(1);
      if (rd_hit[i]) rptr_d[i] = rptr_q[i] + PTR_W'(1);
      case ({wr_hit[i], rd_hit[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
        2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  // Storage is deliberately left out of reset; clearing the counts is enough to discard entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLUX; i++) begin
      if (wr_hit[i]) mem_q[i][wptr_q[i]] <= wr_data;
    end
  end

  // Head selection: lowest requested flux, else lowest non-empty flux.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      if (!sel_found && read_port.read[i]) begin
        sel_idx   = TAG_WIDTH'(i);
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < FLUX; i++) begin
      if (!sel_found && !empty[i]) begin
        sel_idx   = TAG_WIDTH'(i);
        sel_found = 1'b1;
      end
    end
    read_port.dout = '0;
    if (!(&empty)) begin
      read_port.dout = {sel_idx, mem_q[sel_idx][rptr_q[sel_idx]]};
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic err_q;
  logic err_d;
  logic wr_drop;
  logic rd_drop;
  logic rd_multi;

  assign wr_drop  = write_port.write && (wr_hit == '0);
  assign rd_drop  = (read_port.read != '0) && (rd_hit == '0);
  assign rd_multi = (read_port.read & (read_port.read - FLUX'(1))) != '0;

  always_comb begin
    err_d = err_q | wr_drop | rd_drop | rd_multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_flux_fifo.sv
// Directed bench for flux_fifo at default parameters (FLUX=2, DATA_WIDTH=27, DEPTH=4).
// err checks are compiled in only when FIFO_ERR_FLAG_EN is defined.
module tb_flux_fifo;
  localparam int FLUX  = 2;
  localparam int DW    = 27;
  localparam int DEPTH = 4;
  localparam int W     = DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  write_interface #(.FLUX(FLUX), .WIDTH(W)) wif ();
  read_interface  #(.FLUX(FLUX), .WIDTH(W)) rif ();
`ifdef FIFO_ERR_FLAG_EN
  logic err;
`endif

  flux_fifo #(.FLUX(FLUX), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_port (wif),
    .read_port  (rif)
`ifdef FIFO_ERR_FLAG_EN
    ,
    .err        (err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int tag, input int d);
    logic [26:0] dd;
    dd = 27'(d);
    return {4'b0, tag[0], dd};
  endfunction

  task automatic push(input int tag, input int d);
    logic [26:0] dd;
    dd = 27'(d);
    wif.write = 1'b1;
    wif.din   = {tag[0], dd};
    @(posedge clk);
    #1;
    wif.write = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input int f, input int d);
    rif.read = (f == 0) ? 2'b01 : 2'b10;
    #1;
    chk(tag, rif.dout, ent(f, d));
    @(posedge clk);
    #1;
    rif.read = 2'b00;
  endtask

  initial begin
    wif.write = 1'b0;
    wif.din   = '0;
    rif.read  = 2'b00;

    // Reset state
    #12;
    chk("rst_empty", 32'(rif.empty), 32'h3);
    chk("rst_full",  32'(wif.full),  32'h0);
    chk("rst_dout",  rif.dout,       32'h0);
`ifdef FIFO_ERR_FLAG_EN
    chk("rst_err", 32'(err), 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write to flux 1, then read it back
    push(1, 5);
    chk("w1_empty", 32'(rif.empty), 32'h1);
    chk("w1_dout",  rif.dout,       ent(1, 5));
    pop_chk("r1_dout", 1, 5);
    #1;
    chk("r1_empty", 32'(rif.empty), 32'h3);
    chk("r1_dout0", rif.dout,       32'h0);

    // Fill flux 0, overflow write dropped, order preserved
    for (int k = 0; k < 4; k++) push(0, 10 + k);
    chk("fill_full",  32'(wif.full),  32'h1);
    chk("fill_empty", 32'(rif.empty), 32'h2);
    push(0, 14);
    chk("ovf_full", 32'(wif.full), 32'h1);
    for (int k = 0; k < 4; k++) pop_chk("order", 0, 10 + k);
    chk("drain_empty", 32'(rif.empty), 32'h3);

    // Full flux: same-cycle write and read -> read wins, write dropped
    for (int k = 0; k < 4; k++) push(0, 30 + k);
    chk("full2", 32'(wif.full), 32'h1);
    wif.write = 1'b1;
    wif.din   = {1'b0, 27'd20};
    rif.read  = 2'b01;
    #1;
    chk("wr_rd_full_dout", rif.dout, ent(0, 30));
    @(posedge clk);
    #1;
    wif.write = 1'b0;
    rif.read  = 2'b00;
    #1;
    chk("wr_rd_full_flag",  32'(wif.full),  32'h0);
    chk("wr_rd_full_empty", 32'(rif.empty), 32'h2);
    for (int k = 1; k < 4; k++) pop_chk("after_drop", 0, 30 + k);
    chk("after_drop_empty", 32'(rif.empty), 32'h3);

    // Flux 1 with one entry: simultaneous write/read keeps count, wraps pointers
    push(1, 6);
    for (int k = 0; k < 6; k++) begin
      wif.write = 1'b1;
      wif.din   = {1'b1, 27'(7 + k)};
      rif.read  = 2'b10;
      #1;
      chk("pass_head", rif.dout, ent(1, 6 + k));
      @(posedge clk);
      #1;
      wif.write = 1'b0;
      rif.read  = 2'b00;
      #1;
      chk("pass_empty", 32'(rif.empty), 32'h1);
    end
    pop_chk("pass_last", 1, 12);
    chk("pass_drain", 32'(rif.empty), 32'h3);

    // Two read bits: only flux 0 pops
    push(0, 40);
    push(1, 41);
    rif.read = 2'b11;
    #1;
    chk("multi_dout", rif.dout, ent(0, 40));
    @(posedge clk);
    #1;
    rif.read = 2'b00;
    #1;
    chk("multi_empty", 32'(rif.empty), 32'h1);
    chk("multi_head1", rif.dout,       ent(1, 41));
`ifdef FIFO_ERR_FLAG_EN
    chk("multi_err", 32'(err), 32'h1);
`endif

    // Asynchronous reset with three entries queued on flux 1
    push(1, 50);
    push(1, 51);
    chk("pre_rst_empty", 32'(rif.empty), 32'h1);
    chk("pre_rst_full",  32'(wif.full),  32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 32'(rif.empty), 32'h3);
    chk("arst_full",  32'(wif.full),  32'h0);
    chk("arst_dout",  rif.dout,       32'h0);
`ifdef FIFO_ERR_FLAG_EN
    chk("arst_err", 32'(err), 32'h0);
`endif
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(0, 60);
    chk("post_rst_dout",  rif.dout,       ent(0, 60));
    chk("post_rst_empty", 32'(rif.empty), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flux_fifo.md
FLUX_FIFO -- requirements
Module: flux_fifo

Interface
REQ-001 SHALL have parameter FLUX, default 2: number of independent tagged data fluxes, FLUX >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 27: payload bits per entry.
REQ-003 SHALL have parameter DEPTH, default 4: entries per flux; power of two, >= 2.
REQ-004 SHALL derive TAG_WIDTH = $clog2(FLUX) and WIDTH = DATA_WIDTH + TAG_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port write_port.write, input, 1 bit: producer write strobe (write_interface.fifo).
REQ-008 SHALL have port write_port.din, input, WIDTH bits: {tag, data}, tag in the top TAG_WIDTH bits.
REQ-009 SHALL have port write_port.full, output, FLUX bits: per-flux full flag.
REQ-010 SHALL have port read_port.read, input, FLUX bits: per-flux read strobe (read_interface.fifo).
REQ-011 SHALL have port read_port.empty, output, FLUX bits: per-flux empty flag.
REQ-012 SHALL have port read_port.dout, output, WIDTH bits: {tag, head data} of the selected flux.
REQ-013 SHALL have port err, output, 1 bit, present only with FIFO_ERR_FLAG_EN: sticky protocol-error flag.

Function
REQ-014 SHALL keep one circular buffer per flux, each with a write pointer, a read pointer and an occupancy count from 0 to DEPTH.
REQ-015 SHALL drive full[i] = (count[i] == DEPTH) and empty[i] = (count[i] == 0), both from registered state only.
REQ-016 SHALL accept a write when write = 1, tag < FLUX and full[tag] = 0 at the clock edge; the entry is stored at wptr[tag], and wptr increments modulo DEPTH.
REQ-017 SHALL ignore, with no state change, a write to a full flux or a write carrying tag >= FLUX.
REQ-018 SHALL accept read[i] only if empty[i] = 0; rptr[i] increments modulo DEPTH; a read of an empty flux is ignored.
REQ-019 SHALL honour only the lowest-indexed asserted read bit when more than one is asserted; the others are ignored.
REQ-020 SHALL leave count unchanged when a write and a read are both accepted on the same flux in one cycle.
REQ-021 SHALL apply REQ-016 and REQ-018 against the pre-edge flags: a full flux rejects a write even if it is read in the same cycle, and an empty flux rejects a read even if it is written in the same cycle.
REQ-022 SHALL drive dout combinationally as {i, head[i]}, where i is the lowest flux with read[i] = 1; if no read bit is set, i is the lowest non-empty flux; if all fluxes are empty, dout is all zeros.
REQ-023 SHALL have write-to-visible latency of one cycle: a flux written at edge N shows empty = 0 and valid head data after edge N.
REQ-024 SHALL preserve FIFO order within each flux; the fluxes are fully independent of one another.

Reset
REQ-025 SHALL, while rst = 1, asynchronously clear all pointers and counts, which drives empty to all ones, full to all zeros and err to 0.
REQ-026 SHALL not reset storage contents; an assertion of rst mid-operation discards all queued entries.

Configuration
REQ-027 SHALL, with FIFO_ERR_FLAG_EN defined, set err sticky on any of: an ignored write (full or invalid tag), an ignored read (empty), or more than one read bit set; err clears only on rst.
REQ-028 SHALL, without FIFO_ERR_FLAG_EN, omit the err port and its logic; all other behaviour is identical.

Verification
REQ-029 Reset then write tag 1 / data 5 -> next cycle empty = 2'b01, dout = {1, 5}; read[1] -> empty = 2'b11.
REQ-030 Four writes to flux 0 with data 10, 11, 12, 13 (DEPTH = 4) -> full[0] = 1; a fifth write of 14 is ignored; four reads return 10, 11, 12, 13 in order.
REQ-031 Flux 0 full, same-cycle write of 20 and read[0] -> read accepted, write dropped, count = 3, full[0] = 0.
REQ-032 Flux 1 holding one entry, same-cycle write of 7 and read[1] -> count stays 1, head = 7; repeat 6 times -> pointer wrap gives correct order.
REQ-033 read = 2'b11 with both fluxes non-empty -> only flux 0 pops; with FIFO_ERR_FLAG_EN, err = 1 until rst.
REQ-034 Assert rst with 3 entries queued -> empty = 2'b11 and full = 0 immediately, without waiting for a clock edge.
